// File: rtl/alu_iter.sv
// Handshaked execute-stage ALU: single-cycle RV32I ops plus iterative RV32M
// multiply/divide (one bit per cycle, then a sign fixup cycle).
module alu_iter #(
   parameter int unsigned XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [4:0]      i_alu_op,
   input  logic [XLEN-1:0] i_operand_a,
   input  logic [XLEN-1:0] i_operand_b,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_alu_data,
   output logic            o_busy
);

   localparam int unsigned SHW = $clog2(XLEN);
   localparam int unsigned CW  = SHW + 1;
   localparam int unsigned PW  = 2 * XLEN;
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] hi;        // partial product high half / partial remainder
   logic [XLEN-1:0] lo;        // multiplier bits / dividend bits, becomes low product / quotient
   logic [XLEN-1:0] bm;        // multiplicand or divisor magnitude
   logic [2:0]      op_r;      // M-op selector captured at accept
   logic            neg_q;     // negate product / quotient in fixup
   logic            neg_r;     // negate remainder in fixup

   logic            is_mul, is_div, sgn_a, sgn_b, a_neg, b_neg;
   logic            div_zero, div_ovf, fast, iter, accept;
   logic [SHW-1:0]  sh;
   logic [XLEN-1:0] a_mag, b_mag, base_res, quick_res, fix_res;
   logic [PW-1:0]   prod, prod_s;
   logic [XLEN:0]   mac_sum, div_shift, div_diff;

   assign o_ready = !i_rst && !i_flush && (state == IDLE || (state == DONE && i_ready));
   assign accept  = i_valid && o_ready;
   assign o_valid = (state == DONE);
   assign o_busy  = (state == BUSY);

   // Request decode: operand signs/magnitudes, special cases and single-cycle result
   always_comb begin
      is_mul   = i_alu_op[4] & ~i_alu_op[3] & ~i_alu_op[2];
      is_div   = i_alu_op[4] & ~i_alu_op[3] &  i_alu_op[2];
      sgn_a    = 1'b0;
      sgn_b    = 1'b0;
      if (is_mul) begin
         sgn_a = (i_alu_op[1:0] != 2'b11);
         sgn_b = ~i_alu_op[1];
      end else if (is_div) begin
         sgn_a = ~i_alu_op[0];
         sgn_b = ~i_alu_op[0];
      end
      a_neg    = sgn_a & i_operand_a[XLEN-1];
      b_neg    = sgn_b & i_operand_b[XLEN-1];
      a_mag    = a_neg ? -i_operand_a : i_operand_a;
      b_mag    = b_neg ? -i_operand_b : i_operand_b;
      div_zero = (i_operand_b == '0);
      div_ovf  = sgn_a & (i_operand_a == MIN_VAL) & (i_operand_b == '1);
      fast     = is_div & (div_zero | div_ovf);
      iter     = (is_mul | is_div) & ~fast;
      sh       = i_operand_b[SHW-1:0];

      base_res = '0;
      case (i_alu_op[3:0])
         4'b0000: base_res = i_operand_a + i_operand_b;
         4'b0001: base_res = i_operand_a - i_operand_b;
         4'b0010: base_res = i_operand_a ^ i_operand_b;
         4'b0011: base_res = i_operand_a & i_operand_b;
         4'b0100: base_res = i_operand_a | i_operand_b;
         4'b0101: base_res = i_operand_a << sh;
         4'b0110: base_res = i_operand_a >> sh;
         4'b0111: base_res = XLEN'($signed(i_operand_a) >>> sh);
         4'b1000: base_res = XLEN'($signed(i_operand_a) < $signed(i_operand_b));
         4'b1001: base_res = XLEN'(i_operand_a < i_operand_b);
         default: base_res = '0;
      endcase

      quick_res = '0;
      if (!i_alu_op[4]) begin
         quick_res = base_res;
      end else if (fast) begin
         if (div_zero) quick_res = i_alu_op[1] ? i_operand_a : '1;
         else          quick_res = i_alu_op[1] ? '0 : MIN_VAL;
      end
   end

   // One shift-add / restoring-divide step and the final sign fixup
   always_comb begin
      mac_sum   = {1'b0, hi} + (lo[0] ? {1'b0, bm} : '0);
      div_shift = {hi, lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, bm};
      prod      = {hi, lo};
      prod_s    = neg_q ? -prod : prod;
      fix_res   = '0;
      if (op_r[2]) begin
         if (op_r[1]) fix_res = neg_r ? -hi : hi;
         else         fix_res = neg_q ? -lo : lo;
      end else begin
         fix_res = (op_r[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
      end
   end

   // Next-state logic; flush overrides the handshake
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (accept) state_next = iter ? BUSY : DONE;
         BUSY:    if (cnt == CW'(XLEN)) state_next = DONE;
         DONE:    if (i_ready) state_next = accept ? (iter ? BUSY : DONE) : IDLE;
         default: state_next = IDLE;
      endcase
      if (i_flush) state_next = IDLE;
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_next;
   end

   // Datapath: operand capture, iteration and result register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt        <= '0;
         hi         <= '0;
         lo         <= '0;
         bm         <= '0;
         op_r       <= '0;
         neg_q      <= 1'b0;
         neg_r      <= 1'b0;
         o_alu_data <= '0;
      end else if (i_flush) begin
         cnt <= '0;
      end else if (accept) begin
         cnt  <= '0;
         op_r <= i_alu_op[2:0];
         if (iter) begin
            hi    <= '0;
            lo    <= is_mul ? b_mag : a_mag;
            bm    <= is_mul ? a_mag : b_mag;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
         end else begin
            o_alu_data <= quick_res;
         end
      end else if (state == BUSY) begin
         if (cnt != CW'(XLEN)) begin
            cnt <= cnt + CW'(1);
            if (op_r[2]) begin
               if (!div_diff[XLEN]) begin
                  hi <= div_diff[XLEN-1:0];
                  lo <= {lo[XLEN-2:0], 1'b1};
               end else begin
                  hi <= div_shift[XLEN-1:0];
                  lo <= {lo[XLEN-2:0], 1'b0};
               end
            end else begin
               hi <= mac_sum[XLEN:1];
               lo <= {mac_sum[0], lo[XLEN-1:1]};
            end
         end else begin
            o_alu_data <= fix_res;
         end
      end
   end

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed plan cases plus random ops
// compared against a native-arithmetic reference model.
module tb_alu_iter;

   logic        clk = 1'b0;
   logic        rst, flush, req_valid, req_ready, res_valid, res_ready, busy;
   logic [4:0]  alu_op;
   logic [31:0] opa, opb, res_data;

   logic        flush64, req_valid64, req_ready64, res_valid64, res_ready64, busy64;
   logic [4:0]  alu_op64;
   logic [63:0] opa64, opb64, res_data64;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_iter #(.XLEN(32)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(req_valid), .o_ready(req_ready),
      .i_alu_op(alu_op), .i_operand_a(opa), .i_operand_b(opb), .o_valid(res_valid),
      .i_ready(res_ready), .o_alu_data(res_data), .o_busy(busy)
   );

   alu_iter #(.XLEN(64)) u_dut64 (
      .i_clk(clk), .i_rst(rst), .i_flush(flush64), .i_valid(req_valid64), .o_ready(req_ready64),
      .i_alu_op(alu_op64), .i_operand_a(opa64), .i_operand_b(opb64), .o_valid(res_valid64),
      .i_ready(res_ready64), .o_alu_data(res_data64), .o_busy(busy64)
   );

   localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, SLL = 5'd5, SRA = 5'd7, SLTU = 5'd9;
   localparam logic [4:0] MUL = 5'd16, MULH = 5'd17, MULHSU = 5'd18, MULHU = 5'd19;
   localparam logic [4:0] DIV = 5'd20, DIVU = 5'd21, REM = 5'd22, REMU = 5'd23;
   localparam logic [31:0] MINV = 32'h8000_0000;

   // Reference result from plain arithmetic
   function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      logic [31:0] r;
      int sh, ia, ib;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      ia = int'(a);
      ib = int'(b);
      sh = int'(b[4:0]);
      r  = 32'd0;
      case (op)
         5'd0:  r = a + b;
         5'd1:  r = a - b;
         5'd2:  r = a ^ b;
         5'd3:  r = a & b;
         5'd4:  r = a | b;
         5'd5:  r = a << sh;
         5'd6:  r = a >> sh;
         5'd7:  r = 32'($signed(a) >>> sh);
         5'd8:  r = (ia < ib) ? 32'd1 : 32'd0;
         5'd9:  r = (a < b) ? 32'd1 : 32'd0;
         5'd16: begin p = sa * sb; r = p[31:0];  end
         5'd17: begin p = sa * sb; r = p[63:32]; end
         5'd18: begin p = sa * ub; r = p[63:32]; end
         5'd19: begin p = ua * ub; r = p[63:32]; end
         5'd20: r = (b == 0) ? 32'hFFFF_FFFF : ((a == MINV && b == 32'hFFFF_FFFF) ? MINV : 32'(ia / ib));
         5'd21: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         5'd22: r = (b == 0) ? a : ((a == MINV && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib));
         5'd23: r = (b == 0) ? a : a % b;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   // Cycles after the accepting edge until o_valid is seen
   function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op < 5'd16 || op > 5'd23) return 0;
      if (op >= 5'd20) begin
         if (b == 0) return 0;
         if ((op == DIV || op == REM) && a == MINV && b == 32'hFFFF_FFFF) return 0;
      end
      return 33;
   endfunction

   function automatic logic [31:0] pick();
      int sel;
      sel = $urandom_range(0, 7);
      case (sel)
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return MINV;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Present one request, scramble inputs after accept, wait for the result
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output logic busy0);
      req_valid = 1'b1; alu_op = op; opa = a; opb = b;
      @(posedge clk); #1;
      req_valid = 1'b0; alu_op = 5'($urandom); opa = $urandom; opb = $urandom;
      busy0 = busy;
      lat = 0;
      while (!res_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      res = res_data;
   endtask

   task automatic run_op64(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                           output logic [63:0] res, output int lat);
      req_valid64 = 1'b1; alu_op64 = op; opa64 = a; opb64 = b;
      @(posedge clk); #1;
      req_valid64 = 1'b0; opa64 = {$urandom, $urandom}; opb64 = {$urandom, $urandom};
      lat = 0;
      while (!res_valid64 && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      res = res_data64;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b1; alu_op = ADD; opa = $urandom; opb = $urandom; res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", res_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", busy); end
      n_tests++; if (res_data !== 32'd0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", res_data); end
      n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_rst: got %b exp 0", req_ready); end
      rst = 1'b0; req_valid = 1'b0;
      #1;
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b exp 1", req_ready); end
   endtask

   task automatic test_base_directed();
      logic [4:0]  ops[3]  = '{SUB, SRA, SLTU};
      logic [31:0] as[3]   = '{32'd5, 32'h8000_0000, 32'd1};
      logic [31:0] bs[3]   = '{32'd7, 32'h24, 32'hFFFF_FFFF};
      logic [31:0] exps[3] = '{32'hFFFF_FFFE, 32'hF800_0000, 32'd1};
      logic [31:0] r; int lat; logic b0;
      for (int i = 0; i < 3; i++) begin
         run_op(ops[i], as[i], bs[i], r, lat, b0);
         n_tests++; if (r !== exps[i]) begin n_fail++; $display("FAIL base_dir%0d: got %h exp %h", i, r, exps[i]); end
         n_tests++; if (lat !== 0) begin n_fail++; $display("FAIL base_dir%0d_lat: got %0d exp 0", i, lat); end
      end
   endtask

   task automatic test_base_random();
      logic [31:0] r, a, b; logic [4:0] op; int lat; logic b0;
      for (int i = 0; i < 40; i++) begin
         op = 5'($urandom_range(0, 15)); a = pick(); b = pick();
         run_op(op, a, b, r, lat, b0);
         n_tests++; if (r !== ref_alu(op, a, b)) begin n_fail++; $display("FAIL base_rand op=%0d a=%h b=%h: got %h exp %h", op, a, b, r, ref_alu(op, a, b)); end
         n_tests++; if (lat !== 0) begin n_fail++; $display("FAIL base_rand_lat op=%0d: got %0d exp 0", op, lat); end
      end
   endtask

   task automatic test_mul_div_directed();
      logic [4:0]  ops[9]  = '{MULH, MUL, MULHSU, DIV, REM, DIVU, DIV, REMU, DIV};
      logic [31:0] as[9]   = '{MINV, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'h1234_5678, 32'd9, MINV};
      logic [31:0] bs[9]   = '{MINV, 32'd7, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF};
      logic [31:0] exps[9] = '{32'h4000_0000, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'hFFFF_FFFF, 32'd9, MINV};
      int          lats[9] = '{33, 33, 33, 33, 33, 33, 0, 0, 0};
      logic [31:0] r; int lat; logic b0;
      for (int i = 0; i < 9; i++) begin
         run_op(ops[i], as[i], bs[i], r, lat, b0);
         n_tests++; if (r !== exps[i]) begin n_fail++; $display("FAIL md_dir%0d: got %h exp %h", i, r, exps[i]); end
         n_tests++; if (lat !== lats[i]) begin n_fail++; $display("FAIL md_dir%0d_lat: got %0d exp %0d", i, lat, lats[i]); end
         if (lats[i] != 0) begin
            n_tests++; if (b0 !== 1'b1) begin n_fail++; $display("FAIL md_dir%0d_busy: got %b exp 1", i, b0); end
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL md_dir%0d_busy_done: got %b exp 0", i, busy); end
         end
      end
   endtask

   task automatic test_mul_div_random();
      logic [31:0] r, a, b; logic [4:0] op; int lat; logic b0;
      for (int i = 0; i < 30; i++) begin
         op = 5'(16 + $urandom_range(0, 15)); a = pick(); b = pick();
         run_op(op, a, b, r, lat, b0);
         n_tests++; if (r !== ref_alu(op, a, b)) begin n_fail++; $display("FAIL md_rand op=%0d a=%h b=%h: got %h exp %h", op, a, b, r, ref_alu(op, a, b)); end
         n_tests++; if (lat !== ref_lat(op, a, b)) begin n_fail++; $display("FAIL md_rand_lat op=%0d: got %0d exp %0d", op, lat, ref_lat(op, a, b)); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] r, held, a2, b2; int lat; logic b0;
      a2 = $urandom; b2 = $urandom;
      res_ready = 1'b0;
      run_op(MUL, pick(), pick(), r, lat, b0);
      held = r;
      req_valid = 1'b1; alu_op = ADD; opa = a2; opb = b2;
      for (int i = 0; i < 5; i++) begin
         n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready%0d: got %b exp 0", i, req_ready); end
         @(posedge clk); #1;
         n_tests++; if (res_data !== held || res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d: got %h/%b exp %h/1", i, res_data, res_valid, held); end
      end
      res_ready = 1'b1;
      #1;
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b exp 1", req_ready); end
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_tests++; if (res_valid !== 1'b1 || res_data !== a2 + b2) begin n_fail++; $display("FAIL bp_next: got %h/%b exp %h/1", res_data, res_valid, a2 + b2); end
   endtask

   task automatic test_flush();
      logic [31:0] r, a, b; int lat; logic b0;
      req_valid = 1'b1; alu_op = DIVU; opa = $urandom; opb = 32'd3;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1; req_valid = 1'b1; alu_op = ADD; opa = 32'd1; opb = 32'd2;
      #1;
      n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b exp 0", req_ready); end
      @(posedge clk); #1;
      flush = 1'b0;
      n_tests++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got valid=%b busy=%b exp 0/0", res_valid, busy); end
      run_op(ADD, 32'd1, 32'd2, r, lat, b0);
      n_tests++; if (r !== 32'd3 || lat !== 0) begin n_fail++; $display("FAIL flush_next: got %h lat %0d exp 3 lat 0", r, lat); end
      // drop a completed result even though the consumer is ready
      res_ready = 1'b0;
      run_op(SUB, $urandom, $urandom, r, lat, b0);
      flush = 1'b1; res_ready = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_tests++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL flush_done: got %b exp 0", res_valid); end
      a = pick(); b = pick();
      run_op(MULHU, a, b, r, lat, b0);
      n_tests++; if (r !== ref_alu(MULHU, a, b) || lat !== 33) begin n_fail++; $display("FAIL flush_after: got %h lat %0d exp %h lat 33", r, lat, ref_alu(MULHU, a, b)); end
   endtask

   task automatic test_reset_mid_busy();
      logic [31:0] r, a, b; int lat; logic b0;
      req_valid = 1'b1; alu_op = REM; opa = $urandom; opb = 32'd13;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_tests++; if (res_data !== 32'd0 || busy !== 1'b0 || res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got data=%h busy=%b valid=%b exp 0/0/0", res_data, busy, res_valid); end
      rst = 1'b0;
      a = pick(); b = pick();
      run_op(DIV, a, b, r, lat, b0);
      n_tests++; if (r !== ref_alu(DIV, a, b) || lat !== ref_lat(DIV, a, b)) begin n_fail++; $display("FAIL rst_after: got %h lat %0d exp %h lat %0d", r, lat, ref_alu(DIV, a, b), ref_lat(DIV, a, b)); end
   endtask

   task automatic test_xlen64();
      logic [63:0] r, a, b; int lat;
      run_op64(MULHU, '1, '1, r, lat);
      n_tests++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL x64_mulhu: got %h exp fffffffffffffffe", r); end
      n_tests++; if (lat !== 65) begin n_fail++; $display("FAIL x64_mulhu_lat: got %0d exp 65", lat); end
      run_op64(SLL, 64'd3, 64'h7F, r, lat);
      n_tests++; if (r !== 64'h8000_0000_0000_0000 || lat !== 0) begin n_fail++; $display("FAIL x64_sll: got %h lat %0d exp 8000000000000000 lat 0", r, lat); end
      for (int i = 0; i < 4; i++) begin
         a = {$urandom, $urandom}; b = {32'd0, $urandom} | 64'd1;
         run_op64(DIVU, a, b, r, lat);
         n_tests++; if (r !== a / b || lat !== 65) begin n_fail++; $display("FAIL x64_divu%0d: got %h lat %0d exp %h lat 65", i, r, lat, a / b); end
      end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; req_valid = 1'b0; res_ready = 1'b1;
      alu_op = '0; opa = '0; opb = '0;
      flush64 = 1'b0; req_valid64 = 1'b0; res_ready64 = 1'b1;
      alu_op64 = '0; opa64 = '0; opb64 = '0;
      test_reset();
      test_base_directed();
      test_base_random();
      test_mul_div_directed();
      test_mul_div_random();
      test_backpressure();
      test_flush();
      test_reset_mid_busy();
      test_xlen64();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
